// File: rtl/hsv2rgb.sv
// hsv2rgb: hue/chroma/value triple -> packed {grey,R5,G5,B5} pixel word.
// Define HSV2RGB_FASTMUL_EN for a combinational multiplier (2-edge latency).
module hsv2rgb #(
  parameter logic [6:0] HUE_LIMIT = 7'd96
) (
  input  logic        clk,
  input  logic        res,
  input  logic        write,
  input  logic [6:0]  hue,
  input  logic        hue_invalid,
  input  logic [4:0]  saturation,
  input  logic [4:0]  value,
  output logic        busy,
  output logic        done,
  output logic [15:0] data
);

  typedef enum logic [1:0] {
    IDLE = 2'h0,
    MUL  = 2'h1,
    MAP  = 2'h2
  } state_t;

  state_t     state, state_n;
  logic       grey_q;
  logic [2:0] sec_q;
  logic [4:0] val_q;
  logic [4:0] cp_q;
  logic [8:0] p;
  logic [4:0] cp_in;
  logic       accept;

  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && write;
  assign cp_in  = (saturation < value) ? saturation : value;

`ifdef HSV2RGB_FASTMUL_EN
  logic [3:0] frac_q;

  assign p = {4'b0, cp_q} * {5'b0, frac_q};

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      frac_q <= '0;
    end else if (accept) begin
      frac_q <= hue[3:0];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (write) state_n = MAP;
      MAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
`else
  logic [8:0] acc;
  logic [8:0] mcand;
  logic [3:0] mplier;
  logic [1:0] cnt;

  assign p = acc;

  // One shift-add step per cycle, fraction LSB first.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {4'b0, cp_in};
      mplier <= hue[3:0];
      cnt    <= '0;
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 2'd1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (write) state_n = MUL;
      MUL:     if (cnt == 2'd3) state_n = MAP;
      MAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state  <= IDLE;
      grey_q <= 1'b0;
      sec_q  <= '0;
      val_q  <= '0;
      cp_q   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        grey_q <= hue_invalid | (hue >= HUE_LIMIT);
        sec_q  <= hue[6:4];
        val_q  <= value;
        cp_q   <= cp_in;
      end
    end
  end

  logic [4:0] min_v, d, rise, fall;
  logic [4:0] r, g, b;

  assign min_v = val_q - cp_q;
  assign d     = p[8:4];
  assign rise  = min_v + d;
  assign fall  = val_q - d;

  always_comb begin
    r = val_q;
    g = val_q;
    b = val_q;
    priority case (1'b1)
      grey_q:          ;
      (sec_q == 3'd0): begin r = val_q; g = rise;  b = min_v; end
      (sec_q == 3'd1): begin r = fall;  g = val_q; b = min_v; end
      (sec_q == 3'd2): begin r = min_v; g = val_q; b = rise;  end
      (sec_q == 3'd3): begin r = min_v; g = fall;  b = val_q; end
      (sec_q == 3'd4): begin r = rise;  g = min_v; b = val_q; end
      default:         begin r = val_q; g = min_v; b = fall;  end
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      done <= 1'b0;
      data <= '0;
    end else begin
      done <= 1'b0;
      if (state == MAP) begin
        data <= {grey_q, r, g, b};
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hsv2rgb.sv
// Directed-vector bench for hsv2rgb.
// Expected pixels are hand-computed from the HSV sector table.
module tb_hsv2rgb;

`ifdef HSV2RGB_FASTMUL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 5;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        write = 1'b0;
  logic [6:0]  hue = '0;
  logic        hue_invalid = 1'b0;
  logic [4:0]  saturation = '0;
  logic [4:0]  value = '0;
  logic        busy;
  logic        done;
  logic [15:0] data;

  int n_chk = 0;
  int n_pass = 0;

  hsv2rgb dut (
    .clk         (clk),
    .res         (res),
    .write       (write),
    .hue         (hue),
    .hue_invalid (hue_invalid),
    .saturation  (saturation),
    .value       (value),
    .busy        (busy),
    .done        (done),
    .data        (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start(input logic [6:0] h, input logic inv,
                       input logic [4:0] s, input logic [4:0] v);
    @(negedge clk);
    hue = h;
    hue_invalid = inv;
    saturation = s;
    value = v;
    write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic wait_done(input int from, output int n);
    n = from;
    while (n <= 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic count_dones(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) k++;
    end
  endtask

  task automatic convert(input string tag, input logic [6:0] h,
                         input logic inv, input logic [4:0] s,
                         input logic [4:0] v, input logic [15:0] exp);
    int n;
    start(h, inv, s, v);
    check({tag, ".busy"}, busy, 1);
    wait_done(0, n);
    check({tag, ".lat"}, n, LAT);
    check({tag, ".data"}, data, exp);
    check({tag, ".idle"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, done, 0);
    check({tag, ".hold"}, data, exp);
  endtask

  initial begin
    int n, k;
    #1;
    check("rst.done", done, 0);
    check("rst.data", data, 0);
    check("rst.busy", busy, 0);
    repeat (2) @(negedge clk);
    res = 1'b1;

    convert("t1", 7'h00, 1'b0, 5'd31, 5'd31, 16'h7C00);
    convert("t2", 7'h18, 1'b0, 5'd16, 5'd20, 16'h3284);
    convert("t3", 7'h00, 1'b1, 5'd7,  5'd10, 16'hA94A);
    convert("t4", 7'h4F, 1'b0, 5'd25, 5'd9,  16'h2009);
    convert("t5a", 7'h60, 1'b0, 5'd31, 5'd31, 16'hFFFF);
    convert("t5b", 7'h5F, 1'b0, 5'd31, 5'd31, 16'h7C02);
    convert("s2", 7'h28, 1'b0, 5'd16, 5'd20, 16'h128C);
    convert("s3", 7'h38, 1'b0, 5'd16, 5'd20, 16'h1194);
    convert("f5", 7'h05, 1'b0, 5'd31, 5'd31, 16'h7D20);
    convert("f10", 7'h0A, 1'b0, 5'd31, 5'd31, 16'h7E60);

`ifndef HSV2RGB_FASTMUL_EN
    // Writes at E2 and E3 land while busy and must be dropped.
    start(7'h18, 1'b0, 5'd16, 5'd20);
    @(posedge clk);
    @(negedge clk);
    hue = 7'h00;
    saturation = 5'd31;
    value = 5'd31;
    write = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    write = 1'b0;
    wait_done(3, n);
    check("t6.lat", n, LAT);
    check("t6.data", data, 16'h3284);
    count_dones(10, k);
    check("t6.single", k, 0);

    // Reset at E3 aborts the conversion.
    start(7'h38, 1'b0, 5'd16, 5'd20);
    repeat (3) @(posedge clk);
    #2;
    res = 1'b0;
    #1;
    check("t6r.done", done, 0);
    check("t6r.data", data, 0);
    check("t6r.busy", busy, 0);
    @(negedge clk);
    res = 1'b1;
    count_dones(8, k);
    check("t6r.nodone", k, 0);
    convert("t6r.after", 7'h00, 1'b0, 5'd31, 5'd31, 16'h7C00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
